// File: rtl/sram_access_controller_if.sv
// Request/response interface between the two requesters and the SRAM controller.
//   Req0/We0/Addr0/WData0 : port 0 (instruction fetch) request, held until Ack0
//   Req1/We1/Addr1/WData1 : port 1 (data) request, held until Ack1
//   Ack0/Ack1             : one-cycle completion pulses
//   RData                 : read data, valid in the Ack cycle, held until the next read
//   Busy                  : controller is in an access
// Modports: master = requester side, slave = controller side.
interface sram_access_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  Req0;
    logic                  We0;
    logic [ADDR_WIDTH-1:0] Addr0;
    logic [DATA_WIDTH-1:0] WData0;
    logic                  Ack0;
    logic                  Req1;
    logic                  We1;
    logic [ADDR_WIDTH-1:0] Addr1;
    logic [DATA_WIDTH-1:0] WData1;
    logic                  Ack1;
    logic [DATA_WIDTH-1:0] RData;
    logic                  Busy;

    modport master (
        output Req0, We0, Addr0, WData0,
        output Req1, We1, Addr1, WData1,
        input  Ack0, Ack1, RData, Busy
    );

    modport slave (
        input  Req0, We0, Addr0, WData0,
        input  Req1, We1, Addr1, WData1,
        output Ack0, Ack1, RData, Busy
    );
endinterface

// File: rtl/sram_access_controller.sv
// Two-port arbiter and phase sequencer for the three-strobe 1024x32 SRAM.
// Grants one word read/write at a time to port 0 or port 1 and sequences the
// SRAM through address setup, MAR strobe (Clock1), MDR strobe (Clock2) and
// either an output-enable read cycle or a write-commit strobe (Clock3),
// followed by a dead DONE cycle carrying the Ack.
// Ports:
//   Clock, Reset   : system clock, synchronous active-high reset
//   bus (slave)    : Req/We/Addr/WData/Ack per port, RData, Busy
//   SramData       : bidirectional SRAM data bus
//   SramAdx        : SRAM address bus (bit 10 always 0)
//   SramOE         : active-low output enable
//   SramRNW        : 1 = read, 0 = write
//   SramClk1/2/3   : MAR load, MDR load, write commit strobes
module sram_access_controller #(
    parameter int FIXED_PRIORITY = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    sram_access_controller_if.slave bus,
    inout  wire  [DATA_WIDTH-1:0] SramData,
    output logic [ADDR_WIDTH:0]   SramAdx,
    output logic                  SramOE,
    output logic                  SramRNW,
    output logic                  SramClk1,
    output logic                  SramClk2,
    output logic                  SramClk3
);

    typedef enum logic [2:0] {
        IDLE,
        ADR_SET,
        ADR_STB,
        MDR_STB,
        RD_OE,
        WR_STB,
        DONE
    } state_t;

    state_t state, state_next;

    logic grant_port, grant_port_next;
    logic last_grant, last_grant_next;

    logic                  lat_we, lat_we_next;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_next;
    logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_next;

    logic                  drive;
    logic                  drive_next;
    logic [ADDR_WIDTH:0]   adx_next;
    logic                  oe_next, rnw_next;
    logic                  clk1_next, clk2_next, clk3_next;
    logic                  ack0_next, ack1_next, busy_next;

    // Tie: round-robin favours the port not granted last; fixed priority favours port 0.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1)
            return (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
        return r1 & ~r0;
    endfunction

    // The enable comes from a register, so only the mux itself is combinational.
    assign SramData = drive ? lat_wdata : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_next      = state;
        grant_port_next = grant_port;
        last_grant_next = last_grant;
        lat_we_next     = lat_we;
        lat_addr_next   = lat_addr;
        lat_wdata_next  = lat_wdata;

        case (state)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    grant_port_next = pick_winner(bus.Req0, bus.Req1, last_grant);
                    last_grant_next = grant_port_next;
                    lat_we_next     = grant_port_next ? bus.We1    : bus.We0;
                    lat_addr_next   = grant_port_next ? bus.Addr1  : bus.Addr0;
                    lat_wdata_next  = grant_port_next ? bus.WData1 : bus.WData0;
                    state_next      = ADR_SET;
                end
            end
            ADR_SET: state_next = ADR_STB;
            ADR_STB: state_next = MDR_STB;
            MDR_STB: state_next = lat_we ? WR_STB : RD_OE;
            RD_OE:   state_next = DONE;
            WR_STB:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the state being entered so they can be
        // registered and still line up with that state.
        adx_next   = SramAdx;
        oe_next    = 1'b1;
        rnw_next   = 1'b1;
        drive_next = 1'b0;
        clk1_next  = 1'b0;
        clk2_next  = 1'b0;
        clk3_next  = 1'b0;
        ack0_next  = 1'b0;
        ack1_next  = 1'b0;
        busy_next  = (state_next != IDLE);

        case (state_next)
            ADR_SET: begin
                adx_next   = {1'b0, lat_addr_next};
                rnw_next   = ~lat_we_next;
                drive_next = lat_we_next;
            end
            ADR_STB: begin
                rnw_next   = ~lat_we_next;
                drive_next = lat_we_next;
                clk1_next  = 1'b1;
            end
            MDR_STB: begin
                rnw_next   = ~lat_we_next;
                drive_next = lat_we_next;
                clk2_next  = 1'b1;
            end
            RD_OE: begin
                oe_next = 1'b0;
            end
            WR_STB: begin
                rnw_next   = 1'b0;
                drive_next = 1'b1;
                clk3_next  = 1'b1;
            end
            DONE: begin
                ack0_next = ~grant_port_next;
                ack1_next = grant_port_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            grant_port <= 1'b0;
            last_grant <= 1'b1;
            drive      <= 1'b0;
            SramAdx    <= '0;
            SramOE     <= 1'b1;
            SramRNW    <= 1'b1;
            SramClk1   <= 1'b0;
            SramClk2   <= 1'b0;
            SramClk3   <= 1'b0;
            bus.Ack0   <= 1'b0;
            bus.Ack1   <= 1'b0;
            bus.Busy   <= 1'b0;
            bus.RData  <= '0;
        end else begin
            state      <= state_next;
            grant_port <= grant_port_next;
            last_grant <= last_grant_next;
            drive      <= drive_next;
            SramAdx    <= adx_next;
            SramOE     <= oe_next;
            SramRNW    <= rnw_next;
            SramClk1   <= clk1_next;
            SramClk2   <= clk2_next;
            SramClk3   <= clk3_next;
            bus.Ack0   <= ack0_next;
            bus.Ack1   <= ack1_next;
            bus.Busy   <= busy_next;
            if (state == RD_OE)
                bus.RData <= SramData;
        end
    end

    // Request copies: only meaningful while an access is in flight.
    always_ff @(posedge Clock) begin
        lat_we    <= lat_we_next;
        lat_addr  <= lat_addr_next;
        lat_wdata <= lat_wdata_next;
    end

endmodule
